gpio_stream_ctrl: RTL

- Parametrised successor to the PS-GPIO control splitter for the stream mux path.
- Resynchronises a GPIO control word from the PS into the stream clock domain and decodes it into enable, drop and a SEL_WIDTH-bit select.
- Committed outputs change only at AXI-Stream packet boundaries of the monitored stream, so the downstream mux never switches mid-packet.
- A configurable timeout forces the commit if the stream stalls inside a packet.

---
 rtl/gpio_stream_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/gpio_stream_ctrl.sv
// PS-GPIO control splitter for the stream mux path: resynchronises the control word
// and commits enable/drop/sel only at packet boundaries of the monitored stream.
module gpio_stream_ctrl #(
  parameter int unsigned SEL_WIDTH     = 1,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned TIMEOUT       = 0,
  parameter int unsigned TIMEOUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SEL_WIDTH+1:0] gpio,
  input  logic                 mon_tvalid,
  input  logic                 mon_tready,
  input  logic                 mon_tlast,
  output logic                 enable,
  output logic                 drop,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 pending,
  output logic                 switch_done,
  output logic                 timeout
);

  localparam int unsigned CFG_WIDTH = SEL_WIDTH + 2;
  localparam bit          TO_EN     = (TIMEOUT != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST =
    TIMEOUT_WIDTH'(TO_EN ? (TIMEOUT - 1) : 0);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  logic [CFG_WIDTH-1:0]     sync_q [SYNC_STAGES];
  logic [CFG_WIDTH-1:0]     req_c;
  logic [CFG_WIDTH-1:0]     cfg_c;
  logic                     in_packet_q;
  logic                     hs_c;
  logic                     commit_ok_c;
  logic                     commit_c;
  logic                     force_c;
  logic [TIMEOUT_WIDTH-1:0] cnt_q;
  logic [TIMEOUT_WIDTH-1:0] cnt_nxt;
  state_t                   state_q;
  state_t                   state_nxt;

  // Per-bit synchroniser; bits are not coherent, the latest request simply wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gpio;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign req_c   = sync_q[SYNC_STAGES-1];
  assign cfg_c   = {sel, drop, enable};
  assign pending = (req_c != cfg_c);

  // A first beat without tlast closes the boundary until that packet's tlast.
  assign hs_c        = mon_tvalid & mon_tready;
  assign commit_ok_c = in_packet_q ? (hs_c & mon_tlast) : !(hs_c & !mon_tlast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_packet_q <= 1'b0;
    end else if (hs_c) begin
      in_packet_q <= !mon_tlast;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // Next state, timeout counter and commit decision.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    commit_c  = 1'b0;
    force_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_nxt = '0;
        if (pending && commit_ok_c) begin
          commit_c = 1'b1;
        end else if (pending) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!pending) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (commit_ok_c) begin
          commit_c  = 1'b1;
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          commit_c  = 1'b1;
          force_c   = 1'b1;
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + TIMEOUT_WIDTH'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Committed configuration and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable      <= 1'b0;
      drop        <= 1'b0;
      sel         <= '0;
      switch_done <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      switch_done <= commit_c;
      timeout     <= force_c;
      if (commit_c) begin
        enable <= req_c[0];
        drop   <= req_c[1];
        sel    <= req_c[CFG_WIDTH-1:2];
      end
    end
  end

endmodule
